vend_coin_feeder: RTL

- Coin-side initiator for the cola vending controller (price Rs15; coins Rs5/Rs10; OPEN/CHANGE outputs).
- Holds a loaded wallet of Rs5/Rs10 coins. On a buy request it drives one coin per slot on the controller's 4-bit COIN bus.
- Watches OPEN/CHANGE and checks them against its own running total. Reports done, errors, remaining coins and completed vends.

---
 rtl/vend_pkg.sv | 27 ++
 rtl/vend_coin_feeder.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/vend_pkg.sv
// Shared definitions for the cola vending coin feeder.
//   COIN_* : encodings driven on the 4-bit controller coin bus
//   PRICE  : cola price in rupees
//   feeder_state_t : feeder FSM states
//   err_code_t     : error codes reported on err_code
package vend_pkg;

  localparam logic [3:0] COIN_NONE = 4'd0;
  localparam logic [3:0] COIN_5    = 4'd5;
  localparam logic [3:0] COIN_10   = 4'd10;
  localparam int unsigned PRICE    = 15;

  typedef enum logic [1:0] {
    StIdle,
    StPick,
    StDrop,
    StSettle
  } feeder_state_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_NOFUNDS  = 2'd1,
    ERR_PROTO    = 2'd2,
    ERR_LOADBUSY = 2'd3
  } err_code_t;

endpackage

// File: rtl/vend_coin_feeder.sv
// Coin-side initiator for the cola vending controller.
// Holds a wallet of Rs5/Rs10 coins and, on buy, feeds one coin per slot onto the
// controller coin bus, cross-checking OPEN/CHANGE against its own running total.
//
// Ports:
//   clk, reset            clock, asynchronous active-low reset (shared with controller)
//   load, load_n5/_n10    wallet load, honoured in IDLE only
//   buy                   request one cola, sampled in IDLE
//   open_i, change_i      controller responses, valid in the same cycle as coin
//   coin                  registered coin bus (0 / 5 / 10)
//   busy                  FSM not in IDLE
//   done, err             one-cycle pulses; err_code holds until next err or reset
//   n5_left, n10_left     remaining wallet coins
//   vend_cnt              completed vends, wraps
//
// Build option: define CHANGE_RECYCLE_EN to return a valid Rs5 change coin to
// the wallet (n5 saturates).
module vend_coin_feeder
  import vend_pkg::*;
#(
  parameter int unsigned WW         = 4,
  parameter int unsigned CW         = 8,
  parameter bit          PREFER_TEN = 1'b0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [WW-1:0] load_n5,
  input  logic [WW-1:0] load_n10,
  input  logic          buy,
  input  logic          open_i,
  input  logic          change_i,
  output logic [3:0]    coin,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [1:0]    err_code,
  output logic [WW-1:0] n5_left,
  output logic [WW-1:0] n10_left,
  output logic [CW-1:0] vend_cnt
);

  // Wide enough for 5*n5 + 10*n10 at full wallet.
  localparam int unsigned FW = WW + 5;

  feeder_state_t state_q, state_d;
  logic [3:0]    coin_q, coin_d;
  logic [3:0]    paid_q, paid_d;
  logic [WW-1:0] n5_q, n5_d;
  logic [WW-1:0] n10_q, n10_d;
  logic [CW-1:0] vend_cnt_q, vend_cnt_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  err_code_t     err_code_q, err_code_d;

  logic [FW-1:0] funds;
  logic [4:0]    paid_sum;
  logic          exp_open;
  logic          exp_change;
  logic [3:0]    pick_coin;

  always_comb begin
    funds = FW'(n5_q) * FW'(5) + FW'(n10_q) * FW'(10);
  end

  // Coin selection: preferred denomination, falling back to the other one.
  always_comb begin
    pick_coin = COIN_NONE;
    if (PREFER_TEN) begin
      if (n10_q != '0)      pick_coin = COIN_10;
      else if (n5_q != '0)  pick_coin = COIN_5;
    end else begin
      if (n5_q != '0)       pick_coin = COIN_5;
      else if (n10_q != '0) pick_coin = COIN_10;
    end
  end

  always_comb begin
    paid_sum   = {1'b0, paid_q} + {1'b0, coin_q};
    exp_open   = (paid_sum >= 5'(PRICE));
    exp_change = (paid_q == COIN_10) && (coin_q == COIN_10);
  end

  always_comb begin
    state_d    = state_q;
    coin_d     = coin_q;
    paid_d     = paid_q;
    n5_d       = n5_q;
    n10_d      = n10_q;
    vend_cnt_d = vend_cnt_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    err_code_d = err_code_q;

    // Late load is flagged but never disturbs the vend; state-specific errors
    // below take precedence when both fire in the same cycle.
    if ((state_q != StIdle) && load) begin
      err_d      = 1'b1;
      err_code_d = ERR_LOADBUSY;
    end

    case (state_q)
      StIdle: begin
        coin_d = COIN_NONE;
        if (load) begin
          n5_d  = load_n5;
          n10_d = load_n10;
        end else if (buy) begin
          if (funds >= FW'(PRICE)) begin
            state_d = StPick;
          end else begin
            err_d      = 1'b1;
            err_code_d = ERR_NOFUNDS;
          end
        end
      end

      StPick: begin
        coin_d = pick_coin;
        if (pick_coin == COIN_10) begin
          n10_d   = n10_q - WW'(1);
          state_d = StDrop;
        end else if (pick_coin == COIN_5) begin
          n5_d    = n5_q - WW'(1);
          state_d = StDrop;
        end else begin
          err_d      = 1'b1;
          err_code_d = ERR_NOFUNDS;
          state_d    = StIdle;
        end
      end

      StDrop: begin
        coin_d = COIN_NONE;
        if ((open_i != exp_open) || (change_i != exp_change)) begin
          err_d      = 1'b1;
          err_code_d = ERR_PROTO;
          paid_d     = 4'd0;
          state_d    = StIdle;
        end else if (open_i) begin
          paid_d  = 4'd0;
          state_d = StSettle;
`ifdef CHANGE_RECYCLE_EN
          if (change_i && (n5_q != {WW{1'b1}})) begin
            n5_d = n5_q + WW'(1);
          end
`endif
        end else begin
          paid_d  = paid_q + coin_q;
          state_d = StPick;
        end
      end

      StSettle: begin
        // Gap covering the controller's return to its idle state.
        coin_d     = COIN_NONE;
        done_d     = 1'b1;
        vend_cnt_d = vend_cnt_q + CW'(1);
        state_d    = StIdle;
      end

      default: begin
        coin_d  = COIN_NONE;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      coin_q     <= COIN_NONE;
      paid_q     <= 4'd0;
      n5_q       <= '0;
      n10_q      <= '0;
      vend_cnt_q <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      coin_q     <= coin_d;
      paid_q     <= paid_d;
      n5_q       <= n5_d;
      n10_q      <= n10_d;
      vend_cnt_q <= vend_cnt_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  assign coin     = coin_q;
  assign busy     = (state_q != StIdle);
  assign done     = done_q;
  assign err      = err_q;
  assign err_code = err_code_q;
  assign n5_left  = n5_q;
  assign n10_left = n10_q;
  assign vend_cnt = vend_cnt_q;

endmodule
